// File: rtl/alu_sweep_checker.sv
// Stimulus-side checker for the 8-bit combinational ALU: sweeps all 16 opcodes
// on a latched operand pair, compares each result with a golden model and counts mismatches.
module alu_sweep_checker #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] x_seed,
    input  logic [7:0] y_seed,
    output logic [3:0] alu_ctrl,
    output logic [7:0] alu_x,
    output logic [7:0] alu_y,
    input  logic       alu_carry,
    input  logic [7:0] alu_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic [3:0] first_fail
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] IDLE_CTRL = 4'b1101;
    localparam logic [3:0] HOLD_LAST = 4'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [3:0]  hold_q, hold_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [4:0]  err_q, err_d;
    logic [3:0]  ff_q, ff_d;
    logic        pass_q, pass_d;
    logic        done_q, done_d;
    logic [8:0]  expected;
    logic        last_hold;
    logic        mismatch;

    assign last_hold = (hold_q == HOLD_LAST);

    // Golden model of the ALU on the operands currently being driven.
    always_comb begin
        expected = 9'd0;
        case (ctrl_q)
            4'h0: expected = {1'b0, x_q} + {1'b0, y_q};
            4'h1: expected = {1'b0, x_q} - {1'b0, y_q};
            4'h2: expected = {1'b0, x_q & y_q};
            4'h3: expected = {1'b0, x_q | y_q};
            4'h4: expected = {1'b0, ~x_q};
            4'h5: expected = {1'b0, x_q ^ y_q};
            4'h6: expected = {1'b0, ~(x_q | y_q)};
            4'h7: expected = {1'b0, y_q << x_q[2:0]};
            4'h8: expected = {1'b0, y_q >> x_q[2:0]};
            4'h9: expected = {1'b0, x_q[7], x_q[7:1]};
            4'hA: expected = {1'b0, x_q[6:0], x_q[7]};
            4'hB: expected = {1'b0, x_q[0], x_q[7:1]};
            4'hC: expected = {8'd0, (x_q == y_q)};
            default: expected = 9'd0;
        endcase
    end

    assign mismatch = ({alu_carry, alu_out} != expected);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (last_hold && ctrl_q == 4'hF) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q == S_RUN) || (state_q == S_DONE);
    end

    always_comb begin
        hold_d = hold_q;
        ctrl_d = ctrl_q;
        x_d    = x_q;
        y_d    = y_q;
        err_d  = err_q;
        ff_d   = ff_q;
        pass_d = pass_q;
        done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    hold_d = 4'd0;
                    ctrl_d = 4'h0;
                    x_d    = x_seed;
                    y_d    = y_seed;
                    err_d  = 5'd0;
                    ff_d   = 4'h0;
                    pass_d = 1'b0;
                end
            end
            S_RUN: begin
                if (last_hold) begin
                    hold_d = 4'd0;
                    if (mismatch) begin
                        err_d = err_q + 5'd1;
                        if (err_q == 5'd0) ff_d = ctrl_q;
                    end
                    // After the final opcode the ALU is parked on the idle drive at once.
                    if (ctrl_q == 4'hF) begin
                        ctrl_d = IDLE_CTRL;
                        x_d    = 8'd0;
                        y_d    = 8'd0;
                    end else begin
                        ctrl_d = ctrl_q + 4'd1;
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
                pass_d = (err_q == 5'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= 4'd0;
            ctrl_q <= IDLE_CTRL;
            x_q    <= 8'd0;
            y_q    <= 8'd0;
            err_q  <= 5'd0;
            ff_q   <= 4'h0;
            pass_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            ctrl_q <= ctrl_d;
            x_q    <= x_d;
            y_q    <= y_d;
            err_q  <= err_d;
            ff_q   <= ff_d;
            pass_q <= pass_d;
            done_q <= done_d;
        end
    end

    assign alu_ctrl   = ctrl_q;
    assign alu_x      = x_q;
    assign alu_y      = y_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Directed bench for alu_sweep_checker: two instances (SETTLE=1 and SETTLE=3),
// each driving a behavioural ALU that can optionally inject faults.
module tb_alu_sweep_checker;

    logic clk = 1'b0;
    logic rst_n;
    logic fault;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // SETTLE=1 instance
    logic       start1;
    logic [7:0] xs1, ys1, ax1, ay1, o1;
    logic [3:0] ctrl1, ff1;
    logic       c1, busy1, done1, pass1;
    logic [4:0] err1;

    // SETTLE=3 instance
    logic       start3;
    logic [7:0] xs3, ys3, ax3, ay3, o3;
    logic [3:0] ctrl3, ff3;
    logic       c3, busy3, done3, pass3;
    logic [4:0] err3;

    logic [3:0] ctrl_log [0:63];
    logic [8:0] resp1 [0:15];

    function automatic logic [8:0] alu_model(input logic [3:0] c, input logic [7:0] x,
                                             input logic [7:0] y, input logic flt);
        logic [8:0] r;
        case (c)
            4'h0: r = {1'b0, x} + {1'b0, y};
            4'h1: r = {1'b0, x} - {1'b0, y};
            4'h2: r = {1'b0, x & y};
            4'h3: r = {1'b0, x | y};
            4'h4: r = {1'b0, ~x};
            4'h5: r = {1'b0, x ^ y};
            4'h6: r = {1'b0, ~(x | y)};
            4'h7: r = {1'b0, y << x[2:0]};
            4'h8: r = {1'b0, y >> x[2:0]};
            4'h9: r = {1'b0, x[7], x[7:1]};
            4'hA: r = {1'b0, x[6:0], x[7]};
            4'hB: r = {1'b0, x[0], x[7:1]};
            4'hC: r = {8'd0, (x == y)};
            default: r = 9'd0;
        endcase
        if (flt && c == 4'h5) r[0] = ~r[0];
        if (flt && c == 4'h2) r[8] = 1'b1;
        return r;
    endfunction

    assign {c1, o1} = alu_model(ctrl1, ax1, ay1, fault);
    assign {c3, o3} = alu_model(ctrl3, ax3, ay3, fault);

    alu_sweep_checker #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .x_seed(xs1), .y_seed(ys1),
        .alu_ctrl(ctrl1), .alu_x(ax1), .alu_y(ay1), .alu_carry(c1), .alu_out(o1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_fail(ff1)
    );

    alu_sweep_checker #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .x_seed(xs3), .y_seed(ys3),
        .alu_ctrl(ctrl3), .alu_x(ax3), .alu_y(ay3), .alu_carry(c3), .alu_out(o3),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .first_fail(ff3)
    );

    // Start a SETTLE=1 sweep, log opcode/response per cycle, return cycles from E0 to done.
    task automatic sweep1(input logic [7:0] x, input logic [7:0] y, output int lat);
        @(negedge clk);
        xs1 = x; ys1 = y; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = -1;
        for (int i = 0; i <= 200; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (i < 64) ctrl_log[i] = ctrl1;
            if (i < 16) resp1[i] = {c1, o1};
            if (done1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if (ctrl1 !== 4'hD || ax1 !== 8'h00 || ay1 !== 8'h00)
            begin errors++; $display("FAIL reset_drive got ctrl=%h x=%h y=%h want D 00 00", ctrl1, ax1, ay1); end
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 1'b0)
            begin errors++; $display("FAIL reset_flags got busy=%b done=%b pass=%b want 0 0 0", busy1, done1, pass1); end
        checks++;
        if (err1 !== 5'd0 || ff1 !== 4'h0)
            begin errors++; $display("FAIL reset_counts got err=%0d ff=%h want 0 0", err1, ff1); end
        $display("reset: ctrl=%h busy=%b err=%0d", ctrl1, busy1, err1);
    endtask

    task automatic test_nominal();
        int lat;
        int bad;
        sweep1(8'h96, 8'h2D, lat);
        bad = 0;
        for (int k = 0; k < 16; k++) if (ctrl_log[k] !== 4'(k)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL nom_walk got %0d wrong opcodes want 0", bad); end
        checks++;
        if (resp1[0] !== 9'h0C3) begin errors++; $display("FAIL nom_op0 got %h want 0C3", resp1[0]); end
        checks++;
        if (resp1[1] !== 9'h069) begin errors++; $display("FAIL nom_op1 got %h want 069", resp1[1]); end
        checks++;
        if (resp1[4] !== 9'h069) begin errors++; $display("FAIL nom_op4 got %h want 069", resp1[4]); end
        checks++;
        if (resp1[7] !== 9'h040) begin errors++; $display("FAIL nom_op7 got %h want 040", resp1[7]); end
        checks++;
        if (lat != 17) begin errors++; $display("FAIL nom_done_lat got %0d want 17", lat); end
        checks++;
        if (err1 !== 5'd0 || pass1 !== 1'b1 || busy1 !== 1'b0)
            begin errors++; $display("FAIL nom_result got err=%0d pass=%b busy=%b want 0 1 0", err1, pass1, busy1); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (done1 !== 1'b0 || pass1 !== 1'b1 || ctrl1 !== 4'hD || ax1 !== 8'h00)
            begin errors++; $display("FAIL nom_idle got done=%b pass=%b ctrl=%h x=%h want 0 1 D 00", done1, pass1, ctrl1, ax1); end
        $display("nominal: lat=%0d err=%0d pass=%b", lat, err1, pass1);
    endtask

    task automatic test_carry();
        int lat;
        sweep1(8'hFF, 8'h01, lat);
        checks++;
        if (resp1[0] !== 9'h100) begin errors++; $display("FAIL carry_add got %h want 100", resp1[0]); end
        checks++;
        if (lat != 17 || pass1 !== 1'b1) begin errors++; $display("FAIL carry_pass got lat=%0d pass=%b want 17 1", lat, pass1); end
        $display("carry add: resp=%h pass=%b", resp1[0], pass1);
        sweep1(8'h00, 8'h01, lat);
        checks++;
        if (resp1[1] !== 9'h1FF) begin errors++; $display("FAIL borrow_sub got %h want 1FF", resp1[1]); end
        checks++;
        if (lat != 17 || pass1 !== 1'b1) begin errors++; $display("FAIL borrow_pass got lat=%0d pass=%b want 17 1", lat, pass1); end
        $display("borrow sub: resp=%h pass=%b", resp1[1], pass1);
    endtask

    task automatic test_fault();
        int lat;
        fault = 1'b1;
        sweep1(8'h96, 8'h2D, lat);
        fault = 1'b0;
        checks++;
        if (lat != 17) begin errors++; $display("FAIL fault_lat got %0d want 17", lat); end
        checks++;
        if (err1 !== 5'd2) begin errors++; $display("FAIL fault_err got %0d want 2", err1); end
        checks++;
        if (ff1 !== 4'h2) begin errors++; $display("FAIL fault_first got %h want 2", ff1); end
        checks++;
        if (pass1 !== 1'b0) begin errors++; $display("FAIL fault_pass got %b want 0", pass1); end
        $display("fault: err=%0d first=%h pass=%b", err1, ff1, pass1);
    endtask

    task automatic test_equality();
        int lat;
        sweep1(8'hA5, 8'hA5, lat);
        checks++;
        if (resp1[12] !== 9'h001) begin errors++; $display("FAIL eq_op12 got %h want 001", resp1[12]); end
        checks++;
        if (resp1[5] !== 9'h000) begin errors++; $display("FAIL eq_op5 got %h want 000", resp1[5]); end
        checks++;
        if (resp1[6] !== 9'h05A) begin errors++; $display("FAIL eq_op6 got %h want 05A", resp1[6]); end
        checks++;
        if (lat != 17 || pass1 !== 1'b1 || err1 !== 5'd0)
            begin errors++; $display("FAIL eq_pass got lat=%0d pass=%b err=%0d want 17 1 0", lat, pass1, err1); end
        $display("equality: op12=%h pass=%b", resp1[12], pass1);
    endtask

    task automatic test_settle3();
        int lat;
        int bad;
        logic busy_late;
        busy_late = 1'b1;
        @(negedge clk);
        xs3 = 8'h5A; ys3 = 8'h3C; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        checks++;
        if (busy3 !== 1'b1 || ctrl3 !== 4'h0 || ax3 !== 8'h5A || ay3 !== 8'h3C)
            begin errors++; $display("FAIL s3_start got busy=%b ctrl=%h x=%h y=%h want 1 0 5A 3C", busy3, ctrl3, ax3, ay3); end
        lat = -1;
        bad = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (i < 48 && ctrl3 !== 4'(i / 3)) bad++;
            if (i == 10) start3 = 1'b1;
            if (i == 11) start3 = 1'b0;
            if (done3 && lat < 0) lat = i;
            if (i == 55) busy_late = busy3;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL s3_walk got %0d wrong cycles want 0", bad); end
        checks++;
        if (lat != 49) begin errors++; $display("FAIL s3_done_lat got %0d want 49", lat); end
        checks++;
        if (pass3 !== 1'b1 || err3 !== 5'd0) begin errors++; $display("FAIL s3_pass got pass=%b err=%0d want 1 0", pass3, err3); end
        checks++;
        if (busy_late !== 1'b0) begin errors++; $display("FAIL s3_no_requeue got busy=%b want 0", busy_late); end
        $display("settle3: lat=%0d pass=%b", lat, pass3);
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen_done;
        int seen_busy;
        @(negedge clk);
        xs1 = 8'h12; ys1 = 8'h34; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (ctrl1 !== 4'h6) begin errors++; $display("FAIL rmid_op6 got ctrl=%h want 6", ctrl1); end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ctrl1 !== 4'hD || ax1 !== 8'h00 || ay1 !== 8'h00 || busy1 !== 1'b0 ||
            done1 !== 1'b0 || pass1 !== 1'b0 || err1 !== 5'd0 || ff1 !== 4'h0)
            begin errors++; $display("FAIL rmid_outputs got ctrl=%h x=%h y=%h busy=%b done=%b pass=%b err=%0d ff=%h want D 00 00 0 0 0 0 0",
                                     ctrl1, ax1, ay1, busy1, done1, pass1, err1, ff1); end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        seen_busy = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done1) seen_done++;
            if (busy1) seen_busy++;
        end
        checks++;
        if (seen_done != 0 || seen_busy != 0)
            begin errors++; $display("FAIL rmid_no_done got done=%0d busy=%0d cycles want 0 0", seen_done, seen_busy); end
        sweep1(8'h96, 8'h2D, lat);
        checks++;
        if (lat != 17 || pass1 !== 1'b1 || err1 !== 5'd0)
            begin errors++; $display("FAIL rmid_restart got lat=%0d pass=%b err=%0d want 17 1 0", lat, pass1, err1); end
        $display("reset mid-sweep: restart lat=%0d pass=%b", lat, pass1);
    endtask

    initial begin
        rst_n = 1'b0;
        fault = 1'b0;
        start1 = 1'b0; xs1 = 8'h00; ys1 = 8'h00;
        start3 = 1'b0; xs3 = 8'h00; ys3 = 8'h00;
        @(posedge clk);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_nominal();
        test_carry();
        test_fault();
        test_equality();
        test_settle3();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
